seq_scan_ctrl: RTL and testbench

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_pkg.sv | 28 ++
 rtl/seq_match_core.sv | 57 +++++
 rtl/seq_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the serial pattern scan controller.
package seq_scan_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned LEN_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp a programmed length into the legal range 1..max_len.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned max_len);
    logic [LEN_W-1:0] res;
    if (len == '0) begin
      res = LEN_W'(1);
    end else if (32'(len) > max_len) begin
      res = LEN_W'(max_len);
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit history, fill counter and masked compare for the scan controller.
// SEQ_OVERLAP_EN: when defined, history survives a match so overlapping
// occurrences are counted; otherwise the fill restarts after each match.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_bit,
  input  logic               i_valid,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_clear,
  output logic               o_match_c
);

  localparam int unsigned FILL_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;

  // Next history/fill and match including the bit being accepted now.
  always_comb begin
    w_hist_nxt = {r_hist[MAX_LEN-2:0], i_bit};
    w_fill_inc = (r_fill == FILL_W'(MAX_LEN)) ? r_fill : r_fill + FILL_W'(1);
    w_mask     = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(i_len));
    end
    w_match = i_valid && (32'(w_fill_inc) >= 32'(i_len)) &&
              ((w_hist_nxt & w_mask) == (i_pattern & w_mask));
  end

  assign o_match_c = w_match;

  // History and fill update on accepted bits.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_valid) begin
      r_hist <= w_hist_nxt;
`ifdef SEQ_OVERLAP_EN
      r_fill <= w_fill_inc;
`else
      r_fill <= w_match ? '0 : w_fill_inc;
`endif
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serial pattern scan controller: IDLE/SCAN/DONE FSM, match counter,
// bit handshake; the match datapath lives in seq_match_core.
// Optional build macro: SEQ_OVERLAP_EN (overlapping match counting).
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               x,
  input  logic               x_valid,
  output logic               x_ready,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_clear;
  logic               w_accept;
  logic               w_match;
  logic               w_hit_target;
  logic [CNT_W-1:0]   w_cnt_inc;

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_z;
  logic               r_busy;
  logic               r_done;
  logic               r_x_ready;

  assign w_accept = x_valid && (r_state == SCAN);

  seq_match_core #(
    .MAX_LEN (MAX_LEN)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_bit     (x),
    .i_valid   (w_accept),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .i_clear   (w_clear),
    .o_match_c (w_match)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, scan-entry clear and target detection; stop beats start.
  always_comb begin
    w_state_nxt  = r_state;
    w_clear      = 1'b0;
    w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    w_hit_target = w_match && (r_target != '0) && (w_cnt_inc == r_target);
    case (r_state)
      IDLE: begin
        if (!stop && start) begin
          w_state_nxt = SCAN;
          w_clear     = 1'b1;
        end
      end
      SCAN: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (w_hit_target) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (start) begin
          w_state_nxt = SCAN;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Configuration capture, ignored while scanning.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= '0;
      r_len     <= LEN_W'(1);
      r_target  <= '0;
    end else if (cfg_we && (r_state != SCAN)) begin
      r_pattern <= cfg_pattern;
      r_len     <= clamp_len(cfg_len, MAX_LEN);
      r_target  <= cfg_target;
    end
  end

  // Saturating match counter, held outside SCAN until the next start.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_cnt <= '0;
    end else if (w_match) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // Registered status and match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_x_ready <= 1'b0;
    end else begin
      r_z       <= w_match;
      r_busy    <= (w_state_nxt == SCAN);
      r_done    <= (w_state_nxt == DONE);
      r_x_ready <= (w_state_nxt == SCAN);
    end
  end

  assign x_ready   = r_x_ready;
  assign z         = r_z;
  assign match_cnt = r_cnt;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: driver queues the expected z for
// every accepted bit, a negedge monitor pops and compares.
module tb_seq_scan_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               stop;
  logic               x;
  logic               x_valid;
  logic               x_ready;
  logic               z;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;

  int  n_checks = 0;
  int  n_fail   = 0;
  logic exp_q[$];
  logic acc_prev = 1'b0;

  seq_scan_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_target(cfg_target), .start(start), .stop(stop),
    .x(x), .x_valid(x_valid), .x_ready(x_ready), .z(z),
    .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: z one cycle after each accepted bit, never otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (acc_prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_accept: z=%0b with empty scoreboard at %0t", z, $time);
        end else begin
          logic e;
          e = exp_q.pop_front();
          n_checks--;
          chk("z_pulse", 32'(z), 32'(e));
        end
      end else begin
        chk("z_idle", 32'(z), 32'd0);
      end
      acc_prev = x_valid && x_ready;
    end
  end

  // All tasks start and end at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic exp_z, input logic exp_acc);
    x       = b;
    x_valid = 1'b1;
    chk("x_ready", 32'(x_ready), 32'(exp_acc));
    if (exp_acc) exp_q.push_back(exp_z);
    tick();
    x_valid = 1'b0;
  endtask

  // Sends bits[n-1] first down to bits[0]; zs aligned the same way.
  task automatic send_seq(input logic [15:0] bits, input logic [15:0] zs,
                          input int n, input logic exp_acc);
    for (int i = n - 1; i >= 0; i--) send(bits[i], zs[i], exp_acc);
  endtask

  task automatic config_wr(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_target = tgt;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s; stop = p;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
    tick(); tick();
    chk("rst_x_ready", 32'(x_ready), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Basic 1011 stream, unlimited target.
    config_wr(8'b1011, 4'd4, 8'd0);
    pulse(1'b1, 1'b0);
    chk("scan_busy", 32'(busy), 32'd1);
`ifdef SEQ_OVERLAP_EN
    send_seq(16'b001011011, 16'b000001001, 9, 1'b1);
    chk("cnt_overlap", 32'(match_cnt), 32'd2);
`else
    send_seq(16'b001011011, 16'b000001000, 9, 1'b1);
    chk("cnt_nooverlap", 32'(match_cnt), 32'd1);
`endif
    pulse(1'b0, 1'b1);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_x_ready", 32'(x_ready), 32'd0);
    send(1'b1, 1'b0, 1'b0);
`ifdef SEQ_OVERLAP_EN
    chk("cnt_held", 32'(match_cnt), 32'd2);
`else
    chk("cnt_held", 32'(match_cnt), 32'd1);
`endif

    // Target 2 ends the scan on the second match.
    config_wr(8'b1011, 4'd4, 8'd2);
    pulse(1'b1, 1'b0);
    chk("start_clears_cnt", 32'(match_cnt), 32'd0);
`ifdef SEQ_OVERLAP_EN
    send_seq(16'b001011011, 16'b000001001, 9, 1'b1);
`else
    send_seq(16'b10111011, 16'b00010001, 8, 1'b1);
`endif
    chk("tgt_done", 32'(done), 32'd1);
    chk("tgt_busy", 32'(busy), 32'd0);
    chk("tgt_x_ready", 32'(x_ready), 32'd0);
    send_seq(16'b1011, 16'b0000, 4, 1'b0);
    chk("tgt_cnt", 32'(match_cnt), 32'd2);

    // Restart from DONE with gaps between bits.
    config_wr(8'b1011, 4'd4, 8'd0);
    pulse(1'b1, 1'b0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_cnt", 32'(match_cnt), 32'd0);
    send_seq(16'b10, 16'b00, 2, 1'b1);
    tick(); tick(); tick();
    send_seq(16'b11, 16'b01, 2, 1'b1);
    chk("gap_cnt", 32'(match_cnt), 32'd1);
    pulse(1'b0, 1'b1);

    // Reset mid-scan abandons the scan.
    pulse(1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b0, 1'b1);
    x = 1'b1; x_valid = 1'b1; rst = 1'b1;
    exp_q.push_back(1'b0);
    tick();
    rst = 1'b0; x_valid = 1'b0;
    send(1'b1, 1'b0, 1'b0);
    chk("rstmid_cnt", 32'(match_cnt), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);

    // Start and stop together in IDLE: stop wins.
    pulse(1'b1, 1'b1);
    chk("startstop_busy", 32'(busy), 32'd0);

    // Config write during SCAN is ignored.
    config_wr(8'b1011, 4'd4, 8'd0);
    pulse(1'b1, 1'b0);
    config_wr(8'b0000, 4'd4, 8'd0);
    send_seq(16'b1011, 16'b0001, 4, 1'b1);
    chk("cfg_ignored_cnt", 32'(match_cnt), 32'd1);
    pulse(1'b0, 1'b1);

    // Length 0 clamps to 1: every 1 matches.
    config_wr(8'h01, 4'd0, 8'd0);
    pulse(1'b1, 1'b0);
    send_seq(16'b101, 16'b101, 3, 1'b1);
    chk("len0_cnt", 32'(match_cnt), 32'd2);
    pulse(1'b0, 1'b1);

    // Length 15 clamps to 8: first match needs 8 bits.
    config_wr(8'hFF, 4'd15, 8'd0);
    pulse(1'b1, 1'b0);
    send_seq(16'hFF, 16'h01, 8, 1'b1);
    chk("len15_cnt", 32'(match_cnt), 32'd1);
    pulse(1'b0, 1'b1);

    tick(); tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
